// File: rtl/mm_access_sched.sv
// Matching-memory access scheduler: round-robin arbitration between two token
// requesters, lookup/resolve sequencing, occupancy tracking and full-blocking.
module mm_access_sched #(
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mm16,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic             req1_valid,
  output logic             req1_ready,
  output logic             lkup_en,
  output logic             lkup_sel,
  input  logic             mtch_rslt,
  output logic             wr_en,
  output logic             del_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] occ,
  output logic             mm_full
);

  typedef enum logic [1:0] {IDLE, LOOKUP, RESOLVE, EMIT} state_t;

  state_t           state_q, state_d;
  logic             lkup_sel_d;
  logic             last_grant_q, last_grant_d;
  logic [1:0]       block_q, block_d;
  logic [CNT_W-1:0] occ_d;
  logic [CNT_W-1:0] cap;
  logic [1:0]       elig;
  logic             at_cap;
  logic             grant;
  logic             consume;
  logic             lkup_en_d;
  logic             out_valid_d;

  assign cap     = mm16 ? CNT_W'(16) : CNT_W'(32);
  // At-or-above capacity also covers a mode switch that left occ over the limit
  assign at_cap  = (occ >= cap);
  assign mm_full = at_cap;
  assign elig    = {req1_valid & ~block_q[1], req0_valid & ~block_q[0]};

  // Next-state, grant, occupancy and the decoded strobes
  always_comb begin
    state_d      = state_q;
    lkup_sel_d   = lkup_sel;
    last_grant_d = last_grant_q;
    block_d      = block_q;
    occ_d        = occ;
    grant        = 1'b0;
    consume      = 1'b0;
    wr_en        = 1'b0;
    del_en       = 1'b0;

    case (state_q)
      IDLE: begin
        if (|elig) begin
          grant        = elig[~last_grant_q] ? ~last_grant_q : last_grant_q;
          lkup_sel_d   = grant;
          last_grant_d = grant;
          state_d      = LOOKUP;
        end
      end
      LOOKUP: state_d = RESOLVE;
      RESOLVE: begin
        if (mtch_rslt) begin
          del_en  = 1'b1;
          block_d = 2'b00;
          if (occ != '0) occ_d = occ - CNT_W'(1);
          state_d = EMIT;
        end else if (!at_cap) begin
          wr_en   = 1'b1;
          occ_d   = occ + CNT_W'(1);
          consume = 1'b1;
          state_d = IDLE;
        end else begin
          block_d[lkup_sel] = 1'b1;
          state_d           = IDLE;
        end
      end
      EMIT: begin
        if (out_ready) begin
          consume = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    req0_ready  = consume & ~lkup_sel;
    req1_ready  = consume & lkup_sel;
    lkup_en_d   = (state_d == LOOKUP);
    out_valid_d = (state_d == EMIT);
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      lkup_sel     <= 1'b0;
      last_grant_q <= 1'b1;
      block_q      <= 2'b00;
      occ          <= '0;
      lkup_en      <= 1'b0;
      out_valid    <= 1'b0;
    end else begin
      state_q      <= state_d;
      lkup_sel     <= lkup_sel_d;
      last_grant_q <= last_grant_d;
      block_q      <= block_d;
      occ          <= occ_d;
      lkup_en      <= lkup_en_d;
      out_valid    <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_mm_access_sched.sv
// Self-checking bench for mm_access_sched: directed scenarios plus randomized
// traffic against a transaction-level model of occupancy, blocking and round-robin.
module tb_mm_access_sched;
  localparam int unsigned CNT_W = 6;

  logic             clk = 1'b0;
  logic             rst, mm16, req0_valid, req1_valid, mtch_rslt, out_ready;
  logic             req0_ready, req1_ready, lkup_en, lkup_sel, wr_en, del_en;
  logic             out_valid, mm_full;
  logic [CNT_W-1:0] occ;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_occ;
  bit m_block[2];
  int m_last;
  bit v[2];
  int refill_mode;

  mm_access_sched #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .mm16(mm16),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .lkup_en(lkup_en), .lkup_sel(lkup_sel), .mtch_rslt(mtch_rslt),
    .wr_en(wr_en), .del_en(del_en), .out_valid(out_valid), .out_ready(out_ready),
    .occ(occ), .mm_full(mm_full)
  );

  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int cap_f();
    return mm16 ? 16 : 32;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_valid();
    req0_valid = v[0];
    req1_valid = v[1];
  endtask

  task automatic do_reset(input bit m16);
    rst = 1'b1; mm16 = m16; mtch_rslt = 1'b0; out_ready = 1'b0;
    v[0] = 1'b0; v[1] = 1'b0;
    drive_valid();
    step(); step();
    rst = 1'b0;
    m_occ = 0; m_block[0] = 1'b0; m_block[1] = 1'b0; m_last = 1;
  endtask

  // Requester behaviour after its token is consumed
  task automatic consume(input int p);
    case (refill_mode)
      0:       v[p] = 1'b0;
      1:       v[p] = 1'b1;
      default: v[p] = 1'($urandom % 2);
    endcase
    drive_valid();
  endtask

  // One arbitration attempt starting in IDLE; g = expected granted port or -1
  task automatic run_txn(input bit hit, input int stall, output int g);
    int pref, cap;
    bit wrote;
    logic [3:0] exp_o;
    drive_valid();
    pref = 1 - m_last;
    if (v[pref] && !m_block[pref]) g = pref;
    else if (v[1-pref] && !m_block[1-pref]) g = 1 - pref;
    else g = -1;
    mtch_rslt = hit; out_ready = 1'b0;
    step();
    checks++;
    if (g < 0) begin
      if (lkup_en !== 1'b0) begin
        errors++;
        $display("FAIL idle_no_grant: lkup_en=%b expected 0", lkup_en);
      end
      return;
    end
    if ({lkup_en, lkup_sel} !== {1'b1, 1'(g)}) begin
      errors++;
      $display("FAIL lookup: lkup_en=%b lkup_sel=%b expected 1 %0d", lkup_en, lkup_sel, g);
    end
    m_last = g;
    step();
    cap = cap_f();
    wrote = 1'b0;
    if (hit) exp_o = 4'b0100;
    else if (m_occ < cap) begin exp_o = {2'b10, 1'(g == 1), 1'(g == 0)}; wrote = 1'b1; end
    else exp_o = 4'b0000;
    checks++;
    if ({wr_en, del_en, req1_ready, req0_ready} !== exp_o) begin
      errors++;
      $display("FAIL resolve: wr,del,r1,r0=%b expected %b (port %0d hit %0d occ %0d)",
               {wr_en, del_en, req1_ready, req0_ready}, exp_o, g, hit, m_occ);
    end
    if (hit) begin
      if (m_occ > 0) m_occ--;
      m_block[0] = 1'b0; m_block[1] = 1'b0;
    end else if (wrote) m_occ++;
    else m_block[g] = 1'b1;
    step();
    if (hit) begin
      for (int i = 0; i < stall; i++) begin
        checks++;
        if ({out_valid, lkup_en, req1_ready, req0_ready} !== 4'b1000) begin
          errors++;
          $display("FAIL emit_stall: ov,lk,r1,r0=%b expected 1000 (cycle %0d)",
                   {out_valid, lkup_en, req1_ready, req0_ready}, i);
        end
        step();
      end
      out_ready = 1'b1;
      #1;
      checks++;
      if ({out_valid, req1_ready, req0_ready} !== {1'b1, 1'(g == 1), 1'(g == 0)}) begin
        errors++;
        $display("FAIL emit_handshake: ov,r1,r0=%b expected 1 port %0d",
                 {out_valid, req1_ready, req0_ready}, g);
      end
      step();
      out_ready = 1'b0;
      consume(g);
    end else if (wrote) consume(g);
    checks++;
    if ({occ, out_valid, mm_full} !== {CNT_W'(m_occ), 1'b0, 1'(m_occ >= cap)}) begin
      errors++;
      $display("FAIL occupancy: occ=%0d ov=%b full=%b expected occ=%0d ov=0 full=%0d",
               occ, out_valid, mm_full, m_occ, m_occ >= cap);
    end
  endtask

  task automatic test_reset();
    do_reset(1'b1);
    checks++;
    if ({req0_ready, req1_ready, lkup_en, lkup_sel, wr_en, del_en, out_valid, mm_full, occ} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: r0 r1 lk sel wr del ov full=%b occ=%0d expected all 0",
               {req0_ready, req1_ready, lkup_en, lkup_sel, wr_en, del_en, out_valid, mm_full}, occ);
    end
  endtask

  task automatic test_first_miss();
    int g;
    do_reset(1'b1);
    refill_mode = 0;
    v[0] = 1'b1;
    run_txn(1'b0, 0, g);
    run_txn(1'b0, 0, g);
  endtask

  task automatic test_fill16();
    int g;
    do_reset(1'b1);
    refill_mode = 1;
    v[0] = 1'b1; v[1] = 1'b1;
    for (int i = 0; i < 16; i++) run_txn(1'b0, 0, g);
    run_txn(1'b0, 0, g);   // port 0 blocks
    run_txn(1'b1, 4, g);   // port 1 hits with stalled downstream
    run_txn(1'b0, 0, g);   // port 0 regranted and stored
    run_txn(1'b0, 0, g);   // port 1 blocks
    run_txn(1'b0, 0, g);   // port 0 blocks
    run_txn(1'b0, 0, g);   // both blocked: idle
    checks++;
    if (mm_full !== 1'b1) begin
      errors++;
      $display("FAIL full_idle: mm_full=%b expected 1", mm_full);
    end
  endtask

  task automatic test_mm32();
    int g;
    do_reset(1'b0);
    refill_mode = 1;
    v[0] = 1'b1;
    for (int i = 0; i < 33; i++) run_txn(1'b0, 0, g);
    run_txn(1'b0, 0, g);
  endtask

  task automatic test_reset_emit();
    int g;
    do_reset(1'b1);
    refill_mode = 1;
    v[0] = 1'b1;
    run_txn(1'b0, 0, g);
    mtch_rslt = 1'b1;
    step(); step(); step();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL emit_entry: out_valid=%b expected 1", out_valid);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, req0_ready, req1_ready, lkup_en, occ} !== '0) begin
      errors++;
      $display("FAIL reset_in_emit: ov,r0,r1,lk=%b occ=%0d expected 0",
               {out_valid, req0_ready, req1_ready, lkup_en}, occ);
    end
    do_reset(1'b1);
    v[0] = 1'b1; v[1] = 1'b1;
    run_txn(1'b0, 0, g);
    run_txn(1'b1, 2, g);
  endtask

  task automatic test_random();
    int g;
    do_reset(1'($urandom % 2));
    refill_mode = 2;
    for (int n = 0; n < 300; n++) begin
      if (m_block[0] && m_block[1]) do_reset(1'($urandom % 2));
      for (int p = 0; p < 2; p++) if (!v[p]) v[p] = 1'($urandom % 2);
      run_txn(1'($urandom_range(0, 99) < 35), int'($urandom % 4), g);
    end
  endtask

  initial begin
    refill_mode = 0;
    test_reset();
    test_first_miss();
    test_fill16();
    test_mm32();
    test_reset_emit();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mm_access_sched.md
Name: mm_access_sched

Overview:
- Schedules shared access to the 16/32-entry matching memory (MM) between two token requesters: left port 0 and right port 1.
- Each granted token goes through lookup, then resolve. A hit deletes the stored partner and emits the matched pair downstream. A miss stores the token.
- Tracks MM occupancy and blocks requesters when the MM is full.
- Sits between the input token FIFOs and the MM manager / MMU datapath.

Parameters:
- CNT_W, 6, occupancy counter width; must hold 0..32.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- mm16  in  1  1 = 16-entry mode (capacity 16); 0 = 32-entry mode (capacity 32)
- req0_valid  in  1  requester 0 has a token; token held stable until req0_ready
- req0_ready  out  1  one-cycle pulse: requester 0 token consumed
- req1_valid  in  1  requester 1 token valid
- req1_ready  out  1  one-cycle pulse: requester 1 token consumed
- lkup_en  out  1  one-cycle lookup strobe to MM
- lkup_sel  out  1  selects which requester's token drives MM; stable from LOOKUP through end of EMIT
- mtch_rslt  in  1  MM hit; valid in the cycle after lkup_en
- wr_en  out  1  store token into MM (miss)
- del_en  out  1  invalidate matched MM entry (hit)
- out_valid  out  1  matched pair available downstream
- out_ready  in  1  downstream accepts pair
- occ  out  CNT_W  current MM occupancy
- mm_full  out  1  occ equals capacity

Behaviour:
- Reset: clk single clock domain; rst asynchronous, active-high.
  - All outputs 0, occ=0, state IDLE, last_grant=1 (port 0 wins first), block mask 00.
  - Reset mid-operation aborts any transaction; no ready pulse is issued.
- FSM states: IDLE, LOOKUP, RESOLVE, EMIT. All outputs are registered/Moore except req*_ready, wr_en and del_en, which are decoded in RESOLVE/EMIT.
- Eligibility: eligible_n = reqN_valid & ~block[n].
- IDLE:
  - If any requester is eligible, grant round-robin: the port not granted last wins if eligible, else the other.
  - Latch lkup_sel and update last_grant; go to LOOKUP.
  - If none is eligible, stay in IDLE.
- LOOKUP: lkup_en=1 for exactly one cycle; go to RESOLVE.
- RESOLVE samples mtch_rslt:
  - Hit: del_en=1; occ decrements; go to EMIT.
  - Miss with occ < capacity: wr_en=1; occ increments; ready pulse on the granted port; go to IDLE.
  - Miss with occ == capacity: no write and no ready; set block[lkup_sel]; go to IDLE. The token stays pending at the requester.
- EMIT:
  - out_valid=1 until out_ready is sampled high.
  - In that handshake cycle: ready pulse on the granted port, out_valid drops next cycle, go to IDLE.
  - No new grant is issued while in EMIT.
- Latency:
  - Grant decided in cycle T (IDLE); lkup_en at T+1; resolve at T+2.
  - Miss: wr_en and ready at T+2.
  - Hit: del_en at T+2; out_valid from T+3.
  - Minimum 3 cycles per token on a miss.
- Block mask: any occ decrement (hit) clears both block bits in the same clock.
- mm_full = (occ == 16) when mm16=1, (occ == 32) when mm16=0. Combinational from registered occ.
- mm16 changes only while occ==0. If it changes with occ>capacity, mm_full=1 and every miss blocks until occ drains.
- Simultaneous events:
  - req0 and req1 both become valid in the same IDLE cycle: round-robin decides.
  - Both blocked: the FSM idles with mm_full=1 (no deadlock resolution in this block).
- Occupancy saturates: no increment at capacity, no decrement below 0. A hit with occ=0 is a protocol error; occ stays 0 and del_en is still pulsed.

Test Plan:
- Reset, then req0_valid=1 with mtch_rslt=0 -> lkup_en at T+1 with lkup_sel=0; wr_en and req0_ready at T+2; occ=1.
- Both valid continuously, all misses, mm16=1 -> grants alternate 0,1,0,1…; occ reaches 16; mm_full=1; the 17th token gets no wr_en and no ready, and its port is blocked.
- Full (occ=16), blocked port 0, port 1 token hits -> del_en=1, occ=15, block cleared; port 0 regranted next IDLE; write succeeds; occ=16.
- Hit with out_ready held 0 for 4 cycles -> out_valid stays high 4+ cycles; req ready pulses only in the out_ready=1 cycle; no lkup_en during EMIT.
- mm16=0, 32 consecutive misses -> occ=32, mm_full=1; the 33rd miss blocks.
- Assert rst during EMIT with out_valid=1 -> out_valid, occ and ready all go to 0 immediately; after release, first grant goes to port 0.
